cla_seq_adder: RTL and testbench

- Parametrised, multi-cycle carry-lookahead adder. Computes S = A + B + Cin over WIDTH bits, one GROUP-bit lookahead slice per clock.
- Carry ripples between slices through a registered carry.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths as the wide successor to the 4-bit combinational CLA.
- Also reports signed overflow.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group.sv | 51 +++++
 rtl/cla_seq_adder.sv | 132 +++++++++++++
 tb/tb_cla_seq_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
// Holds the FSM state encoding and the index-width sizing helper.
// No logic of its own; imported by cla_seq_adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: sum, carry out and carry into the slice MSB.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the result is used.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             acc;
  logic             prod;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g, p and cin, so no carry waits on another.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int k = j + 1; k <= i; k++) begin
          prod = prod & p[k];
        end
        acc = acc | prod;
      end
      prod = cin;
      for (int k = 0; k <= i; k++) begin
        prod = prod & p[k];
      end
      c[i+1] = acc | prod;
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one GROUP-bit lookahead slice per clock, carry held in a register.
// Latency: out_valid rises after edge NUM_GROUPS counted from the input handshake edge (edge 0).
// Backpressure: in_ready only in IDLE; the result sits in DONE until out_ready is seen on an edge.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NUM_GROUPS = WIDTH / GROUP;
  localparam int IDX_W      = clog2(NUM_GROUPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  // Keeps in_ready low until the first edge after reset release.
  logic             rdy_en_q;

  int               base;
  logic [GROUP-1:0] slice_a;
  logic [GROUP-1:0] slice_b;
  logic [GROUP-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign base    = int'(idx_q) * GROUP;
  assign slice_a = a_q[base +: GROUP];
  assign slice_b = b_q[base +: GROUP];

  cla_group #(
    .GROUP(GROUP)
  ) u_group (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c_msb(slice_cmsb)
  );

  // Next-state and handshake outputs; idx stops at the last slice instead of wrapping.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rdy_en_q;
        if (in_valid && rdy_en_q) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d[base +: GROUP] = slice_sum;
        carry_d            = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including the visible result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks of cla_seq_adder at 16/4 and at 8/8 (single slice).
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, Cin, out_valid, out_ready, Cout, Ovf;
  logic [15:0] A, B, S;
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, s8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  cla_seq_adder #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .Cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .S(s8), .Cout(cout8), .Ovf(ovf8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One add on the 16-bit instance; hold = cycles to keep out_ready low in DONE
  // while in_valid is high with fresh operands.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo, input int hold);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    A = a; B = b; Cin = c; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_calc", 32'(in_ready), 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 4);
    check("sum", 32'(S), 32'(es));
    check("cout", 32'(Cout), 32'(ec));
    check("ovf", 32'(Ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_sum", 32'(S), 32'(es));
      check("hold_cout", 32'(Cout), 32'(ec));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready", 32'(in_ready), 1);
  endtask

  // One add on the single-slice instance: result must be valid one edge after the handshake.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    check("in_ready8_idle", 32'(in_ready8), 1);
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("out_valid8_pre", 32'(out_valid8), 0);
    @(posedge clk);
    @(negedge clk);
    check("out_valid8", 32'(out_valid8), 1);
    check("sum8", 32'(s8), 32'(es));
    check("cout8", 32'(cout8), 32'(ec));
    check("ovf8", 32'(ovf8), 32'(eo));
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("idle8_out_valid", 32'(out_valid8), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[8];
    logic [16:0] r;
    logic [8:0]  r8;
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rc;

    vt[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(S), 0);
    check("rst_cout", 32'(Cout), 0);
    check("rst_ovf", 32'(Ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready_before_edge", 32'(in_ready), 0);

    for (int i = 0; i < 8; i++) begin
      do_add(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].cout, vt[i].ovf, 0);
    end

    // Backpressure: result held for six cycles while new operands are offered.
    do_add(16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 6);

    // Reset during the second CALC cycle: partial sum and old flags vanish at once.
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("partial_sum", 32'(S), 32'h0003);
    check("partial_cout_old", 32'(Cout), 1);
    rst = 1'b1;
    #1;
    check("abort_sum", 32'(S), 0);
    check("abort_cout", 32'(Cout), 0);
    check("abort_ovf", 32'(Ovf), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel2_in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    check("rel2_in_ready_after_edge", 32'(in_ready), 1);
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);

    // Single-slice configuration.
    do_add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      r8 = 9'(ra8) + 9'(rb8) + 9'(rc);
      do_add8(ra8, rb8, rc, r8[7:0], r8[8],
              (ra8[7] == rb8[7]) && (r8[7] != ra8[7]));
    end

    // Random sweep against a plain integer reference, random DONE stall length.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      r = 17'(ra) + 17'(rb) + 17'(rc);
      do_add(ra, rb, rc, r[15:0], r[16],
             (ra[15] == rb[15]) && (r[15] != ra[15]), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
